// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, funct codes,
// datapath mux/ALU/extender encodings, FSM states and instruction classes.
package mips_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_OR    = 6'b100101;

  // ALU operation
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;
  localparam logic [1:0] ALU_LUI  = 2'b11;

  // Immediate extender mode
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HI   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Controller states
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  // Instruction classes produced by the decoder
  typedef enum logic [2:0] {
    IC_R       = 3'd0,
    IC_ORI     = 3'd1,
    IC_LUI     = 3'd2,
    IC_LW      = 3'd3,
    IC_SW      = 3'd4,
    IC_BEQ     = 3'd5,
    IC_J       = 3'd6,
    IC_ILLEGAL = 3'd7
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/funct -> instruction class and
// the ALU operation an R-type instruction needs in EXEC.
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic [1:0] r_aluctrl
);

  // Classify the instruction; anything unrecognised is ILLEGAL.
  always_comb begin
    iclass    = IC_ILLEGAL;
    r_aluctrl = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin iclass = IC_R; r_aluctrl = ALU_ADD; end
          FN_SUBU: begin iclass = IC_R; r_aluctrl = ALU_SUB; end
          FN_OR:   begin iclass = IC_R; r_aluctrl = ALU_OR;  end
          default: iclass = IC_ILLEGAL;
        endcase
      end
      OP_ORI:  iclass = IC_ORI;
      OP_LUI:  iclass = IC_LUI;
      OP_LW:   iclass = IC_LW;
      OP_SW:   iclass = IC_SW;
      OP_BEQ:  iclass = IC_BEQ;
      OP_J:    iclass = IC_J;
      default: iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencing controller: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and mux selects, and
// traps on illegal instructions or a memory that never answers.
module mc_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       PCWr,
  output logic       IorD,
  output logic       MemR,
  output logic       MemW,
  output logic       IRWr,
  output logic       Mem2R,
  output logic       RegDst,
  output logic       RegW,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] Aluctrl,
  output logic [1:0] ExtOp,
  output logic       instr_done,
  output logic       halt,
  output logic [3:0] state
);

  localparam int                WAIT_W     = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                mem_wait;
  iclass_t             iclass;
  logic [1:0]          r_aluctrl;

  logic       pc_wr, i_or_d, mem_r, mem_w, ir_wr, mem2r, reg_dst, reg_w;
  logic       alu_src_a, done, halt_s;
  logic [1:0] alu_src_b, pc_source, aluctrl, ext_op;

  mc_decode u_decode (
    .op        (op),
    .funct     (funct),
    .iclass    (iclass),
    .r_aluctrl (r_aluctrl)
  );

  // Next-state selection plus the memory wait counter; a wait that would
  // reach TIMEOUT cycles diverts to TRAP instead of counting further.
  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    mem_wait = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE; else mem_wait = 1'b1;
      S_DECODE: begin
        case (iclass)
          IC_LW, IC_SW:          state_d = S_MEMADR;
          IC_R, IC_ORI, IC_LUI:  state_d = S_EXEC;
          IC_BEQ:                state_d = S_BRANCH;
          IC_J:                  state_d = S_JUMP;
          default:               state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        case (iclass)
          IC_LW:   state_d = S_MEMRD;
          IC_SW:   state_d = S_MEMWR;
          default: state_d = S_TRAP;
        endcase
      end
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB; else mem_wait = 1'b1;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH; else mem_wait = 1'b1;
      S_EXEC:   state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
    if (mem_wait) begin
      if (wait_q == WAIT_LIMIT) state_d = S_TRAP;
      else                      wait_d  = wait_q + 1'b1;
    end
  end

  // State and wait-counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Per-state datapath controls; only PCWr/IRWr/instr_done see mem_rdy or zero.
  always_comb begin
    pc_wr     = 1'b0;
    i_or_d    = 1'b0;
    mem_r     = 1'b0;
    mem_w     = 1'b0;
    ir_wr     = 1'b0;
    mem2r     = 1'b0;
    reg_dst   = 1'b0;
    reg_w     = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RT;
    pc_source = PCSRC_ALU;
    aluctrl   = ALU_ADD;
    ext_op    = EXT_ZERO;
    done      = 1'b0;
    halt_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_r     = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_wr     = mem_rdy;
        ir_wr     = mem_rdy;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SL2;
        ext_op    = EXT_SIGN;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = EXT_SIGN;
      end
      S_MEMRD: begin
        mem_r  = 1'b1;
        i_or_d = 1'b1;
      end
      S_MEMWB: begin
        reg_w   = 1'b1;
        mem2r   = 1'b1;
        reg_dst = 1'b1;
        done    = 1'b1;
      end
      S_MEMWR: begin
        mem_w  = 1'b1;
        i_or_d = 1'b1;
        done   = mem_rdy;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        case (iclass)
          IC_R:   begin alu_src_b = SRCB_RT;  aluctrl = r_aluctrl; end
          IC_ORI: begin alu_src_b = SRCB_IMM; ext_op = EXT_ZERO; aluctrl = ALU_OR;  end
          IC_LUI: begin alu_src_b = SRCB_IMM; ext_op = EXT_HI;   aluctrl = ALU_LUI; end
          default: ;
        endcase
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        reg_dst = (iclass != IC_R);
        done    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluctrl   = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_wr     = zero;
        done      = 1'b1;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_wr     = 1'b1;
        done      = 1'b1;
      end
      S_TRAP:  halt_s = 1'b1;
      default: halt_s = 1'b1;
    endcase
  end

  // While reset is held every output is forced low so no write can escape.
  assign PCWr       = rst & pc_wr;
  assign IorD       = rst & i_or_d;
  assign MemR       = rst & mem_r;
  assign MemW       = rst & mem_w;
  assign IRWr       = rst & ir_wr;
  assign Mem2R      = rst & mem2r;
  assign RegDst     = rst & reg_dst;
  assign RegW       = rst & reg_w;
  assign ALUSrcA    = rst & alu_src_a;
  assign ALUSrcB    = rst ? alu_src_b : 2'b00;
  assign PCSource   = rst ? pc_source : 2'b00;
  assign Aluctrl    = rst ? aluctrl   : 2'b00;
  assign ExtOp      = rst ? ext_op    : 2'b00;
  assign instr_done = rst & done;
  assign halt       = rst & halt_s;
  assign state      = rst ? state_q : 4'd0;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: walks each instruction class cycle by cycle
// and compares state plus the full control vector with hand-derived values.
module tb_mc_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op, funct;
  logic       zero, mem_rdy;
  logic       PCWr, IorD, MemR, MemW, IRWr, Mem2R, RegDst, RegW, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource, Aluctrl, ExtOp;
  logic       instr_done, halt;
  logic [3:0] state;
  logic [18:0] outs;

  int checks   = 0;
  int failures = 0;

  // Expected control vectors, one per state flavour
  logic [18:0] v_zero, v_frdy, v_fwait, v_dec, v_madr, v_mrd, v_mwb;
  logic [18:0] v_mwr_rdy, v_mwr_wait, v_ex_add, v_ex_sub, v_ex_or;
  logic [18:0] v_ex_ori, v_ex_lui, v_awb_r, v_awb_i, v_br_z, v_br_nz, v_jmp, v_trap;

  always #5 clk = ~clk;

  assign outs = {PCWr, IorD, MemR, MemW, IRWr, Mem2R, RegDst, RegW, ALUSrcA,
                 ALUSrcB, PCSource, Aluctrl, ExtOp, instr_done, halt};

  mc_ctrl #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_rdy    (mem_rdy),
    .PCWr       (PCWr),
    .IorD       (IorD),
    .MemR       (MemR),
    .MemW       (MemW),
    .IRWr       (IRWr),
    .Mem2R      (Mem2R),
    .RegDst     (RegDst),
    .RegW       (RegW),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSource   (PCSource),
    .Aluctrl    (Aluctrl),
    .ExtOp      (ExtOp),
    .instr_done (instr_done),
    .halt       (halt),
    .state      (state)
  );

  function automatic logic [18:0] o(
    input logic pcwr, iord, memr, memw, irwr, mem2r, regdst, regw, srca,
    input logic [1:0] srcb, pcsrc, aluc, ext,
    input logic done, hlt);
    return {pcwr, iord, memr, memw, irwr, mem2r, regdst, regw, srca,
            srcb, pcsrc, aluc, ext, done, hlt};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Check the current cycle (1 ns after the falling edge), then advance one cycle.
  task automatic cyc(input string tag, input state_t est, input logic [18:0] eo);
    #1;
    check({tag, "/state"}, 32'(state), 32'(est));
    check({tag, "/outs"},  32'(outs),  32'(eo));
    @(negedge clk);
  endtask

  task automatic fetch_decode(input string tag, input logic [5:0] o_v, input logic [5:0] f_v);
    op      = o_v;
    funct   = f_v;
    mem_rdy = 1'b1;
    cyc({tag, ".F"}, S_FETCH,  v_frdy);
    cyc({tag, ".D"}, S_DECODE, v_dec);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    cyc({tag, ".rst"}, S_FETCH, v_zero);
    rst = 1'b1;
  endtask

  initial begin
    //             pw io mr mw ir m2 rd rw sa srcb   pcsrc  aluc   ext    dn ht
    v_zero     = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    v_frdy     = o(1, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
    v_fwait    = o(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
    v_dec      = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b01, 0, 0);
    v_madr     = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 2'b01, 0, 0);
    v_mrd      = o(0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    v_mwb      = o(0, 0, 0, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
    v_mwr_rdy  = o(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
    v_mwr_wait = o(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    v_ex_add   = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    v_ex_sub   = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0);
    v_ex_or    = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 2'b00, 0, 0);
    v_ex_ori   = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    v_ex_lui   = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b11, 2'b10, 0, 0);
    v_awb_r    = o(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
    v_awb_i    = o(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
    v_br_z     = o(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 2'b00, 1, 0);
    v_br_nz    = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 2'b00, 1, 0);
    v_jmp      = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 1, 0);
    v_trap     = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);

    rst = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_rdy = 1'b1;
    @(negedge clk);

    // Reset held three cycles with mem_rdy high: every output must stay low
    for (int i = 0; i < 3; i++) cyc($sformatf("reset%0d", i), S_FETCH, v_zero);
    rst = 1'b1;
    $display("txn reset");

    // addu / subu / or
    fetch_decode("addu", OP_RTYPE, FN_ADDU);
    cyc("addu.E", S_EXEC, v_ex_add);
    cyc("addu.W", S_ALUWB, v_awb_r);
    $display("txn addu cycles=4");
    fetch_decode("subu", OP_RTYPE, FN_SUBU);
    cyc("subu.E", S_EXEC, v_ex_sub);
    cyc("subu.W", S_ALUWB, v_awb_r);
    $display("txn subu cycles=4");
    fetch_decode("or", OP_RTYPE, FN_OR);
    cyc("or.E", S_EXEC, v_ex_or);
    cyc("or.W", S_ALUWB, v_awb_r);
    $display("txn or cycles=4");

    // ori / lui
    fetch_decode("ori", OP_ORI, 6'h15);
    cyc("ori.E", S_EXEC, v_ex_ori);
    cyc("ori.W", S_ALUWB, v_awb_i);
    $display("txn ori cycles=4");
    fetch_decode("lui", OP_LUI, 6'h00);
    cyc("lui.E", S_EXEC, v_ex_lui);
    cyc("lui.W", S_ALUWB, v_awb_i);
    $display("txn lui cycles=4");

    // lw with two wait cycles in MEMRD: 7 cycles total
    fetch_decode("lw", OP_LW, 6'h00);
    cyc("lw.A", S_MEMADR, v_madr);
    mem_rdy = 1'b0;
    cyc("lw.R0", S_MEMRD, v_mrd);
    cyc("lw.R1", S_MEMRD, v_mrd);
    mem_rdy = 1'b1;
    cyc("lw.R2", S_MEMRD, v_mrd);
    cyc("lw.W", S_MEMWB, v_mwb);
    $display("txn lw cycles=7");

    // beq taken and not taken
    fetch_decode("beqz", OP_BEQ, 6'h00);
    zero = 1'b1;
    cyc("beqz.B", S_BRANCH, v_br_z);
    $display("txn beq-taken cycles=3");
    zero = 1'b0;
    fetch_decode("beqn", OP_BEQ, 6'h00);
    cyc("beqn.B", S_BRANCH, v_br_nz);
    $display("txn beq-not-taken cycles=3");

    // j, then sw
    fetch_decode("j", OP_J, 6'h00);
    cyc("j.J", S_JUMP, v_jmp);
    $display("txn j cycles=3");
    fetch_decode("sw", OP_SW, 6'h00);
    cyc("sw.A", S_MEMADR, v_madr);
    cyc("sw.M", S_MEMWR, v_mwr_rdy);
    cyc("sw.next", S_FETCH, v_frdy);
    $display("txn sw cycles=4");
    do_reset("sw");

    // Illegal opcode: TRAP after DECODE, sticky until reset
    fetch_decode("ill3f", 6'b111111, 6'h00);
    cyc("ill3f.T0", S_TRAP, v_trap);
    zero = 1'b1;
    cyc("ill3f.T1", S_TRAP, v_trap);
    mem_rdy = 1'b0;
    cyc("ill3f.T2", S_TRAP, v_trap);
    zero = 1'b0; mem_rdy = 1'b1;
    do_reset("ill3f");
    $display("txn illegal-op trap");

    // Illegal R-type funct
    fetch_decode("illfn", OP_RTYPE, 6'b000000);
    cyc("illfn.T0", S_TRAP, v_trap);
    cyc("illfn.T1", S_TRAP, v_trap);
    do_reset("illfn");
    cyc("illfn.after", S_FETCH, v_frdy);
    cyc("illfn.dec", S_DECODE, v_dec);
    do_reset("illfn2");
    $display("txn illegal-funct trap");

    // 15 wait cycles in FETCH is still fine
    op = OP_J; funct = 6'h00; mem_rdy = 1'b0;
    for (int i = 0; i < 15; i++) cyc($sformatf("wait15.%0d", i), S_FETCH, v_fwait);
    mem_rdy = 1'b1;
    cyc("wait15.rdy", S_FETCH, v_frdy);
    cyc("wait15.dec", S_DECODE, v_dec);
    cyc("wait15.j", S_JUMP, v_jmp);
    $display("txn fetch-wait15 ok");

    // 16 wait cycles in FETCH traps
    mem_rdy = 1'b0;
    for (int i = 0; i < 16; i++) cyc($sformatf("tmo.%0d", i), S_FETCH, v_fwait);
    cyc("tmo.trap", S_TRAP, v_trap);
    mem_rdy = 1'b1;
    cyc("tmo.stay", S_TRAP, v_trap);
    do_reset("tmo");
    $display("txn fetch-timeout trap");

    // Reset while sw waits in MEMWR: no MemW during reset, FETCH afterwards
    fetch_decode("swrst", OP_SW, 6'h00);
    cyc("swrst.A", S_MEMADR, v_madr);
    mem_rdy = 1'b0;
    cyc("swrst.M", S_MEMWR, v_mwr_wait);
    do_reset("swrst");
    mem_rdy = 1'b1;
    cyc("swrst.after", S_FETCH, v_frdy);
    $display("txn sw-reset abandoned");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencing controller for the MIPS core. It splits each instruction into FETCH, DECODE, EXEC, MEM and WB steps and drives the datapath enables and mux selects for each step. It runs against a single shared instruction/data memory with a ready handshake, and sits between the instruction register's op/funct fields and the existing PC/RF/EXT/ALU/DM datapath. It replaces the combinational single-cycle `Ctrl` decode.

## Interface
- `TIMEOUT`, default 16: maximum cycles a memory state may wait for `mem_rdy` before trapping.
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `op` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_rdy` in 1: shared memory completes the access this cycle.
- `PCWr` out 1: PC load enable.
- `IorD` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemR` out 1: memory read request.
- `MemW` out 1: memory write request.
- `IRWr` out 1: instruction register load.
- `Mem2R` out 1: RF write data select; 1 = MDR, 0 = ALUOut.
- `RegDst` out 1: RF write address select; 1 = rt, 0 = rd.
- `RegW` out 1: RF write enable.
- `ALUSrcA` out 1: ALU A select; 0 = PC, 1 = rs.
- `ALUSrcB` out 2: ALU B select; 00 = rt, 01 = 4, 10 = ext imm, 11 = ext imm<<2.
- `PCSource` out 2: next-PC select; 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 2'b00}.
- `Aluctrl` out 2: ALU op; 00 ADD, 01 SUB, 10 OR, 11 LUI pass-B.
- `ExtOp` out 2: extender mode; 00 zero, 01 sign, 10 imm<<16.
- `instr_done` out 1: one-cycle pulse in the final cycle of every retired instruction.
- `halt` out 1: controller is in TRAP.
- `state` out 4: current state encoding, for debug and checking.

## Operation
- Supported opcodes:
  - 000000 R-type, with funct 100001 addu, 100011 subu, 100101 or.
  - 001101 ori, 001111 lui, 100011 lw, 101011 sw, 000100 beq, 000010 j.
  - Any other op/funct combination goes to TRAP.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, TRAP.
- FETCH
  - Drives MemR=1, IorD=0, ALUSrcA=0, ALUSrcB=01, Aluctrl=ADD, PCSource=00.
  - PCWr=IRWr=mem_rdy. On mem_rdy go to DECODE; otherwise stay.
- DECODE
  - Drives ALUSrcA=0, ALUSrcB=11, ExtOp=01, Aluctrl=ADD (branch target into ALUOut).
  - Next state: lw/sw → MEMADR; R/ori/lui → EXEC; beq → BRANCH; j → JUMP; illegal → TRAP.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ExtOp=01, ADD. Next: lw → MEMRD, sw → MEMWR.
- MEMRD: MemR=1, IorD=1. Wait for mem_rdy, then go to MEMWB.
- MEMWB: RegW=1, Mem2R=1, RegDst=1, instr_done=1. Next: FETCH.
- MEMWR: MemW=1, IorD=1. instr_done=mem_rdy. On mem_rdy go to FETCH.
- EXEC: ALUSrcA=1, then by instruction:
  - R-type: ALUSrcB=00, Aluctrl from funct.
  - ori: ALUSrcB=10, ExtOp=00, OR.
  - lui: ALUSrcB=10, ExtOp=10, Aluctrl=11.
  - Next: ALUWB.
- ALUWB: RegW=1, Mem2R=0, RegDst = 0 for R-type, 1 for ori/lui. instr_done=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, PCWr=zero, instr_done=1. Next: FETCH.
- JUMP: PCSource=10, PCWr=1, instr_done=1. Next: FETCH.
- TRAP: every enable is 0 and halt=1. The controller leaves TRAP only through reset.
- Wait counter
  - Counts consecutive cycles with mem_rdy=0 in FETCH, MEMRD or MEMWR.
  - Clears on mem_rdy or on any state change.
  - Reaching TIMEOUT goes to TRAP.
  - Width is clog2(TIMEOUT+1).
- Any output not listed for a state is 0.

## Timing
- All outputs are Moore decodes of `state`, except PCWr/IRWr/instr_done, which additionally gate on mem_rdy or zero in the same cycle.
- While rst=0:
  - Every output is forced to 0 combinationally (no spurious writes).
  - The next edge loads FETCH and clears the wait counter.
  - `state` reads as FETCH after that edge.
- Reset mid-instruction (including in TRAP): the instruction is abandoned, with no RF/memory write in the reset cycle.
- Cycle counts with mem_rdy held at 1: j 3, beq 3, R-type/ori/lui 4, sw 4, lw 5.
- Each cycle with mem_rdy=0 in a memory state adds exactly one cycle.
- instr_done is exactly one cycle wide per instruction and is never asserted in TRAP.

## Structure
- Package `mips_pkg` holds:
  - opcode and funct localparams;
  - Aluctrl, ExtOp, ALUSrcB and PCSource encodings;
  - the state enum (4 bits).
- One sub-module, `mc_decode`: combinational op/funct → instruction class (R, ORI, LUI, LW, SW, BEQ, J, ILLEGAL) plus the R-type Aluctrl.
- mc_ctrl holds the state register, the wait counter and the output decode.

## Test plan
- Reset and addu
  - Hold rst=0 for 3 cycles, then release.
  - Required: all outputs 0 during reset.
  - Feed op=0, funct=100001, mem_rdy=1. Required state sequence FETCH, DECODE, EXEC, ALUWB, with RegW=1, RegDst=0 in ALUWB and instr_done on cycle 4.
- lw with slow memory
  - mem_rdy low for 2 cycles in MEMRD.
  - Required: total 7 cycles; MemR=1 and IorD=1 held for 3 cycles; Mem2R=1 and RegW=1 in MEMWB.
- beq
  - With zero=1: PCWr=1 and PCSource=01 in BRANCH.
  - With zero=0: PCWr=0 and instr_done=1; 3 cycles either way.
- j, then sw
  - j: PCWr=1, PCSource=10 in cycle 3.
  - sw: MemW=1 for one cycle, RegW never asserted.
- Illegal opcodes
  - op=111111, or op=0 with funct=000000: TRAP after DECODE, halt=1, all enables 0.
  - Only rst=0 leaves TRAP.
- Timeout
  - mem_rdy=0 for 16 cycles in FETCH with TIMEOUT=16: TRAP.
  - Separately, rst=0 asserted in MEMWR: no MemW on the following cycle, state=FETCH.
